// File: rtl/prn_k_scheduler_if.sv
// Control/status bundle between the PRN x K scheduler and its host/datapath.
// The host side drives configuration, start/stop and chip ticks; the scheduler returns K and gating.
interface prn_k_scheduler_if #(
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DEPTH             = 8,
  parameter int DWELL_WIDTH       = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                         cfg_we;
  logic [AW-1:0]                cfg_addr;
  logic [OUTPUT_DATA_WIDTH-1:0] cfg_k;
  logic [AW:0]                  cfg_num;
  logic [DWELL_WIDTH-1:0]       cfg_dwell;
  logic                         cfg_loop;
  logic                         start;
  logic                         stop;
  logic                         chip_tick;
  logic [OUTPUT_DATA_WIDTH-1:0] para_K;
  logic [AW-1:0]                entry_idx;
  logic                         mseq_en;
  logic                         send_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output cfg_we, cfg_addr, cfg_k, cfg_num, cfg_dwell, cfg_loop, start, stop, chip_tick,
    input  para_K, entry_idx, mseq_en, send_valid, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_k, cfg_num, cfg_dwell, cfg_loop, start, stop, chip_tick,
    output para_K, entry_idx, mseq_en, send_valid, busy, done
  );
endinterface

// File: rtl/prn_k_scheduler.sv
// Steps the PRN x K multiplier through a table of K gains, holding each for a chip dwell
// and blanking transmission while the multiplier pipeline settles after every K change.
module prn_k_scheduler #(
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DEPTH             = 8,
  parameter int DWELL_WIDTH       = 16,
  parameter int MULT_LAT          = 4
) (
  input  logic               MSEQ_clk,
  input  logic               MSEQ_rst,
  prn_k_scheduler_if.slave   bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned NUM_W = AW + 1;
  localparam int unsigned LAT_W = $clog2(MULT_LAT + 1);

  localparam logic [AW-1:0]          IDX_ZERO  = '0;
  localparam logic [AW-1:0]          IDX_ONE   = AW'(32'd1);
  localparam logic [NUM_W-1:0]       NUM_ONE   = NUM_W'(32'd1);
  localparam logic [NUM_W-1:0]       NUM_MAX   = NUM_W'(DEPTH);
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(32'd1);
  localparam logic [LAT_W-1:0]       LAT_ONE   = LAT_W'(32'd1);
  localparam logic [LAT_W-1:0]       LAT_LAST  = LAT_W'(MULT_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN, ST_DONE} state_t;

  state_t                       state_r, state_nxt_s;
  logic [OUTPUT_DATA_WIDTH-1:0] k_table_r [DEPTH];
  logic [OUTPUT_DATA_WIDTH-1:0] para_k_r, para_k_nxt_s;
  logic [AW-1:0]                idx_r, idx_nxt_s;
  logic [NUM_W-1:0]             num_r, num_nxt_s;
  logic [DWELL_WIDTH-1:0]       dwell_r, dwell_nxt_s;
  logic                         loop_r, loop_nxt_s;
  logic [DWELL_WIDTH-1:0]       dwell_cnt_r, dwell_cnt_nxt_s;
  logic [LAT_W-1:0]             settle_cnt_r, settle_cnt_nxt_s;
  logic                         mseq_en_r, send_valid_r, busy_r, done_r;
  logic                         num_ok_s, dwell_done_s, last_entry_s;
  logic [DWELL_WIDTH-1:0]       dwell_eff_s;

  assign num_ok_s     = (bus.cfg_num != '0) && (bus.cfg_num <= NUM_MAX);
  assign dwell_eff_s  = (dwell_r == '0) ? DWELL_ONE : dwell_r;
  assign dwell_done_s = (dwell_cnt_r == (dwell_eff_s - DWELL_ONE));
  assign last_entry_s = ({1'b0, idx_r} == (num_r - NUM_ONE));

  // K table storage; the host may only rewrite it while the sequencer is idle
  always_ff @(posedge MSEQ_clk) begin
    if (MSEQ_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        k_table_r[i] <= '0;
      end
    end else if (bus.cfg_we && (state_r == ST_IDLE)) begin
      k_table_r[bus.cfg_addr] <= bus.cfg_k;
    end
  end

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_nxt_s      = state_r;
    para_k_nxt_s     = para_k_r;
    idx_nxt_s        = idx_r;
    num_nxt_s        = num_r;
    dwell_nxt_s      = dwell_r;
    loop_nxt_s       = loop_r;
    dwell_cnt_nxt_s  = dwell_cnt_r;
    settle_cnt_nxt_s = settle_cnt_r;
    case (state_r)
      ST_IDLE: begin
        // stop has priority over start even while idle
        if (bus.start && !bus.stop && num_ok_s) begin
          state_nxt_s      = ST_SETTLE;
          num_nxt_s        = bus.cfg_num;
          dwell_nxt_s      = bus.cfg_dwell;
          loop_nxt_s       = bus.cfg_loop;
          idx_nxt_s        = IDX_ZERO;
          para_k_nxt_s     = k_table_r[IDX_ZERO];
          dwell_cnt_nxt_s  = '0;
          settle_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (bus.stop) begin
          state_nxt_s      = ST_IDLE;
          para_k_nxt_s     = '0;
          idx_nxt_s        = IDX_ZERO;
          settle_cnt_nxt_s = '0;
        end else if (settle_cnt_r == LAT_LAST) begin
          state_nxt_s      = ST_RUN;
          settle_cnt_nxt_s = '0;
        end else begin
          settle_cnt_nxt_s = settle_cnt_r + LAT_ONE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_nxt_s     = ST_IDLE;
          para_k_nxt_s    = '0;
          idx_nxt_s       = IDX_ZERO;
          dwell_cnt_nxt_s = '0;
        end else if (bus.chip_tick) begin
          if (dwell_done_s) begin
            dwell_cnt_nxt_s = '0;
            if (!last_entry_s) begin
              state_nxt_s  = ST_SETTLE;
              idx_nxt_s    = idx_r + IDX_ONE;
              para_k_nxt_s = k_table_r[idx_r + IDX_ONE];
            end else if (loop_r) begin
              state_nxt_s  = ST_SETTLE;
              idx_nxt_s    = IDX_ZERO;
              para_k_nxt_s = k_table_r[IDX_ZERO];
            end else begin
              state_nxt_s = ST_DONE;
            end
          end else begin
            dwell_cnt_nxt_s = dwell_cnt_r + DWELL_ONE;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.stop) begin
          state_nxt_s  = ST_IDLE;
          para_k_nxt_s = '0;
          idx_nxt_s    = IDX_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        para_k_nxt_s = '0;
        idx_nxt_s    = IDX_ZERO;
      end
    endcase
  end

  // State register plus outputs registered from the next state so they align with it
  always_ff @(posedge MSEQ_clk) begin
    if (MSEQ_rst) begin
      state_r      <= ST_IDLE;
      para_k_r     <= '0;
      idx_r        <= '0;
      num_r        <= '0;
      dwell_r      <= '0;
      loop_r       <= 1'b0;
      dwell_cnt_r  <= '0;
      settle_cnt_r <= '0;
      mseq_en_r    <= 1'b0;
      send_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      para_k_r     <= para_k_nxt_s;
      idx_r        <= idx_nxt_s;
      num_r        <= num_nxt_s;
      dwell_r      <= dwell_nxt_s;
      loop_r       <= loop_nxt_s;
      dwell_cnt_r  <= dwell_cnt_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
      mseq_en_r    <= (state_nxt_s == ST_RUN);
      send_valid_r <= (state_nxt_s == ST_RUN);
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= (state_nxt_s == ST_DONE);
    end
  end

  assign bus.para_K     = para_k_r;
  assign bus.entry_idx  = idx_r;
  assign bus.mseq_en    = mseq_en_r;
  assign bus.send_valid = send_valid_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
endmodule
